// File: rtl/cnn1d_pkg.sv
// Shared types and helpers for the cnn1d condition monitor slice.
//
// Contents:
//   mon_state_e : monitor FSM state (NORMAL=0, SUSPECT=1, ALARM=2)
//   class_w()   : width of a class index for a given number of classes
//                 (never less than 1 bit, so a single-class build still has a port)
package cnn1d_pkg;

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    SUSPECT = 2'd1,
    ALARM   = 2'd2
  } mon_state_e;

  function automatic int class_w(input int num_classes);
    return (num_classes <= 2) ? 1 : $clog2(num_classes);
  endfunction

endpackage

// File: rtl/cnn1d_vote_window.sv
// Sliding-window vote counter for cnn1d classifications.
//
// Keeps the last VOTE_WINDOW accepted class indices plus one running count
// per class. Every accept shifts the new class in; once the window is full the
// oldest entry is evicted and its count is decremented on the same edge.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   clear           : synchronous clear of history, counts and fill
//   accept          : a classification is being taken this edge
//   new_class       : class index being accepted
//   decide          : this accept leaves the window full (decision edge)
//   dec_class       : argmax of the post-accept counts, ties to lowest index
//   dec_fault_votes : post-accept count of FAULT_CLASS
module cnn1d_vote_window
  import cnn1d_pkg::*;
#(
  parameter int NUM_NEURONS = 2,
  parameter int VOTE_WINDOW = 8,
  parameter int FAULT_CLASS = 1,
  parameter int CLASS_W     = class_w(NUM_NEURONS),
  parameter int CNT_W       = $clog2(VOTE_WINDOW) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               accept,
  input  logic [CLASS_W-1:0] new_class,
  output logic               decide,
  output logic [CLASS_W-1:0] dec_class,
  output logic [CNT_W-1:0]   dec_fault_votes
);

  logic [CLASS_W-1:0] hist     [VOTE_WINDOW];
  logic [CNT_W-1:0]   cnt      [NUM_NEURONS];
  logic [CNT_W-1:0]   cnt_next [NUM_NEURONS];
  logic [CNT_W-1:0]   fill;
  logic [CNT_W-1:0]   best;
  logic               full;

  assign full   = (fill == CNT_W'(VOTE_WINDOW));
  // The accept that brings fill from VOTE_WINDOW-1 to full already decides.
  assign decide = accept && (full || (fill == CNT_W'(VOTE_WINDOW - 1)));

  // Counts as they will be after this edge. When the incoming and evicted
  // classes match, the +1 and -1 cancel.
  always_comb begin
    for (int i = 0; i < NUM_NEURONS; i++) begin
      cnt_next[i] = cnt[i];
      if (accept && (new_class == CLASS_W'(i)))
        cnt_next[i] = cnt_next[i] + CNT_W'(1);
      if (accept && full && (hist[VOTE_WINDOW-1] == CLASS_W'(i)))
        cnt_next[i] = cnt_next[i] - CNT_W'(1);
    end
  end

  // Strict greater-than so the lowest index wins a tie.
  always_comb begin
    dec_class = '0;
    best      = cnt_next[0];
    for (int i = 1; i < NUM_NEURONS; i++) begin
      if (cnt_next[i] > best) begin
        best      = cnt_next[i];
        dec_class = CLASS_W'(i);
      end
    end
  end

  assign dec_fault_votes = cnt_next[FAULT_CLASS];

  // History shift register, per-class counts and fill level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill <= '0;
      for (int i = 0; i < VOTE_WINDOW; i++) hist[i] <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) cnt[i] <= '0;
    end else if (clear) begin
      fill <= '0;
      for (int i = 0; i < VOTE_WINDOW; i++) hist[i] <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) cnt[i] <= '0;
    end else if (accept) begin
      hist[0] <= new_class;
      for (int i = 1; i < VOTE_WINDOW; i++) hist[i] <= hist[i-1];
      for (int i = 0; i < NUM_NEURONS; i++) cnt[i] <= cnt_next[i];
      if (!full) fill <= fill + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cnn1d_condition_monitor.sv
// Tool-condition monitor behind a cnn1d classifier.
//
// Majority-votes the last VOTE_WINDOW classifications, publishes each decision
// through a one-deep valid/ready output register, and runs a NORMAL/SUSPECT/
// ALARM FSM that latches ALARM after ALARM_HOLD consecutive fault windows.
//
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   cnn_valid        : classification valid from cnn1d
//   cnn_condition    : classification class index
//   cnn_ready        : monitor can take a classification this edge
//   mon_valid        : decision register holds an unconsumed decision
//   mon_ready        : downstream consumes the decision
//   mon_class        : majority class of the window
//   mon_fault_votes  : FAULT_CLASS votes in the window
//   alarm            : FSM is in ALARM
//   state            : encoded FSM state
//   clear            : synchronous clear of window, FSM, decision and count
//   sample_count     : accepted classifications, saturating
module cnn1d_condition_monitor
  import cnn1d_pkg::*;
#(
  parameter int NUM_NEURONS     = 2,
  parameter int VOTE_WINDOW     = 8,
  parameter int FAULT_CLASS     = 1,
  parameter int ALARM_THRESHOLD = 6,
  parameter int ALARM_HOLD      = 4,
  localparam int CLASS_W        = class_w(NUM_NEURONS),
  localparam int VOTE_W         = $clog2(VOTE_WINDOW) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cnn_valid,
  input  logic [CLASS_W-1:0] cnn_condition,
  output logic               cnn_ready,
  output logic               mon_valid,
  input  logic               mon_ready,
  output logic [CLASS_W-1:0] mon_class,
  output logic [VOTE_W-1:0]  mon_fault_votes,
  output logic               alarm,
  output logic [1:0]         state,
  input  logic               clear,
  output logic [31:0]        sample_count
);

  localparam int HOLD_W = $clog2(ALARM_HOLD + 1);

  mon_state_e         state_q;
  logic [HOLD_W-1:0]  hold;
  logic               rdy_en;
  logic               accept;
  logic               decide;
  logic [CLASS_W-1:0] dec_class;
  logic [VOTE_W-1:0]  dec_votes;
  logic               fault_window;

  // rdy_en keeps cnn_ready low during reset and rises on the first edge after
  // release; the rest lets a pending decision drain on the same edge.
  assign cnn_ready    = rdy_en && !clear && (!mon_valid || mon_ready);
  assign accept       = cnn_valid && cnn_ready;
  assign fault_window = (int'(dec_votes) >= ALARM_THRESHOLD);
  assign alarm        = (state_q == ALARM);
  assign state        = state_q;

  cnn1d_vote_window #(
    .NUM_NEURONS (NUM_NEURONS),
    .VOTE_WINDOW (VOTE_WINDOW),
    .FAULT_CLASS (FAULT_CLASS),
    .CLASS_W     (CLASS_W),
    .CNT_W       (VOTE_W)
  ) u_window (
    .clk             (clk),
    .rst             (rst),
    .clear           (clear),
    .accept          (accept),
    .new_class       (cnn_condition),
    .decide          (decide),
    .dec_class       (dec_class),
    .dec_fault_votes (dec_votes)
  );

  // Decision register, sample counter and condition FSM. The FSM only moves
  // on decision edges; clear wins over any concurrent accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_en          <= 1'b0;
      mon_valid       <= 1'b0;
      mon_class       <= '0;
      mon_fault_votes <= '0;
      state_q         <= NORMAL;
      hold            <= '0;
      sample_count    <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (clear) begin
        mon_valid       <= 1'b0;
        mon_class       <= '0;
        mon_fault_votes <= '0;
        state_q         <= NORMAL;
        hold            <= '0;
        sample_count    <= '0;
      end else begin
        if (accept && (sample_count != 32'hFFFF_FFFF))
          sample_count <= sample_count + 32'd1;
        if (decide) begin
          mon_valid       <= 1'b1;
          mon_class       <= dec_class;
          mon_fault_votes <= dec_votes;
          case (state_q)
            NORMAL: begin
              if (fault_window) begin
                hold    <= HOLD_W'(1);
                state_q <= (ALARM_HOLD <= 1) ? ALARM : SUSPECT;
              end
            end
            SUSPECT: begin
              if (fault_window) begin
                hold <= hold + HOLD_W'(1);
                if (int'(hold) + 1 >= ALARM_HOLD) state_q <= ALARM;
              end else begin
                hold    <= '0;
                state_q <= NORMAL;
              end
            end
            ALARM:   state_q <= ALARM;
            default: begin
              hold    <= '0;
              state_q <= NORMAL;
            end
          endcase
        end else if (mon_ready) begin
          mon_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cnn1d_condition_monitor.sv
// Self-checking bench for cnn1d_condition_monitor (default parameters).
// A directed table covers the fill/suspect/alarm sequence, hand-written
// sequences cover ties, backpressure, clear and mid-window reset, and a
// randomized run is checked against a queue-based window model.
module tb_cnn1d_condition_monitor;

  localparam int NN   = 2;
  localparam int VW   = 8;
  localparam int FC   = 1;
  localparam int THR  = 6;
  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cnn_valid = 1'b0;
  logic [0:0]  cnn_condition = '0;
  logic        cnn_ready;
  logic        mon_valid;
  logic        mon_ready = 1'b0;
  logic [0:0]  mon_class;
  logic [3:0]  mon_fault_votes;
  logic        alarm;
  logic [1:0]  state;
  logic        clear = 1'b0;
  logic [31:0] sample_count;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: window as a queue, newest at the front.
  int     m_hist[$];
  bit     m_ren;
  bit     m_mv;
  int     m_class;
  int     m_votes;
  int     m_state;
  int     m_run;
  longint m_count;

  typedef struct {
    bit cv;
    int cond;
    bit exp_valid;
    int exp_class;
    int exp_votes;
    int exp_state;
  } vec_t;

  vec_t tbl[32];

  always #5 clk = ~clk;

  cnn1d_condition_monitor dut (
    .clk             (clk),
    .rst             (rst),
    .cnn_valid       (cnn_valid),
    .cnn_condition   (cnn_condition),
    .cnn_ready       (cnn_ready),
    .mon_valid       (mon_valid),
    .mon_ready       (mon_ready),
    .mon_class       (mon_class),
    .mon_fault_votes (mon_fault_votes),
    .alarm           (alarm),
    .state           (state),
    .clear           (clear),
    .sample_count    (sample_count)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_hist.delete();
    m_ren = 0; m_mv = 0; m_class = 0; m_votes = 0;
    m_state = 0; m_run = 0; m_count = 0;
  endtask

  task automatic modelUpdate(input bit acc, input int cond, input bit mrdy, input bit clr);
    int cnt[NN];
    int best;
    bit loaded = 0;
    if (clr) begin
      m_hist.delete();
      m_mv = 0; m_state = 0; m_run = 0; m_count = 0;
    end else begin
      if (acc) begin
        m_hist.push_front(cond);
        if (m_hist.size() > VW) void'(m_hist.pop_back());
        if (m_count < 64'hFFFF_FFFF) m_count++;
        if (m_hist.size() == VW) begin
          foreach (cnt[c]) cnt[c] = 0;
          foreach (m_hist[k]) cnt[m_hist[k]]++;
          best = 0;
          for (int c = 1; c < NN; c++) if (cnt[c] > cnt[best]) best = c;
          m_mv = 1; m_class = best; m_votes = cnt[FC]; loaded = 1;
          if (m_state != 2) begin
            if (m_votes >= THR) begin
              m_run++;
              m_state = (m_run >= HOLD) ? 2 : 1;
            end else begin
              m_run = 0;
              m_state = 0;
            end
          end
        end
      end
      if (!loaded && mrdy) m_mv = 0;
    end
    m_ren = 1;
  endtask

  task automatic checkModel();
    checkOutput("mon_valid", mon_valid, m_mv);
    checkOutput("state", state, m_state);
    checkOutput("alarm", alarm, m_state == 2);
    checkOutput("sample_count", sample_count, m_count);
    if (m_mv) begin
      checkOutput("mon_class", mon_class, m_class);
      checkOutput("mon_fault_votes", mon_fault_votes, m_votes);
    end
  endtask

  // Called at posedge+1: drive, check ready, take the edge, check outputs.
  task automatic applyStimulus(input bit cv, input int cond, input bit mrdy, input bit clr);
    bit rdy;
    cnn_valid = cv; cnn_condition = cond[0]; mon_ready = mrdy; clear = clr;
    #1;
    rdy = m_ren && !clr && (!m_mv || mrdy);
    checkOutput("cnn_ready", cnn_ready, rdy);
    @(posedge clk);
    #1;
    modelUpdate(cv && rdy, cond, mrdy, clr);
    checkModel();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_cnn_ready"}, cnn_ready, 0);
    checkOutput({tag, "_mon_valid"}, mon_valid, 0);
    checkOutput({tag, "_mon_class"}, mon_class, 0);
    checkOutput({tag, "_votes"}, mon_fault_votes, 0);
    checkOutput({tag, "_alarm"}, alarm, 0);
    checkOutput({tag, "_state"}, state, 0);
    checkOutput({tag, "_sample_count"}, sample_count, 0);
  endtask

  task automatic resetDut();
    rst = 1'b1; cnn_valid = 0; clear = 0; mon_ready = 0;
    @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Directed table: 8 zeros, 16 ones, 8 zeros with mon_ready held high.
    for (int i = 0; i < 32; i++) begin
      int k, ones;
      tbl[i].cv = 1;
      tbl[i].cond = (i >= 8 && i < 24) ? 1 : 0;
      tbl[i].exp_valid = (i >= 7);
      if (i < 8) ones = 0;
      else if (i < 24) ones = (i - 7 > 8) ? 8 : i - 7;
      else ones = 8 - (i - 23);
      tbl[i].exp_votes = ones;
      tbl[i].exp_class = (ones > 4) ? 1 : 0;
      k = i - 7;
      if (i < 24 && k < 6) tbl[i].exp_state = 0;
      else if (i < 24 && k < 9) tbl[i].exp_state = 1;
      else tbl[i].exp_state = 2;
    end

    modelReset();
    resetDut();
    applyStimulus(0, 0, 1, 0);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(tbl[i].cv, tbl[i].cond, 1, 0);
      checkOutput("tbl_valid", mon_valid, tbl[i].exp_valid);
      checkOutput("tbl_state", state, tbl[i].exp_state);
      if (tbl[i].exp_valid) begin
        checkOutput("tbl_class", mon_class, tbl[i].exp_class);
        checkOutput("tbl_votes", mon_fault_votes, tbl[i].exp_votes);
      end
    end
    checkOutput("tbl_alarm_sticky", alarm, 1);

    // Alternating 0/1 after a full window: 4-4 tie goes to class 0.
    resetDut();
    applyStimulus(0, 0, 1, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 1, 0);
    for (int j = 0; j < 8; j++) applyStimulus(1, (j % 2 == 0) ? 1 : 0, 1, 0);
    checkOutput("tie_class", mon_class, 0);
    checkOutput("tie_votes", mon_fault_votes, 4);
    checkOutput("tie_state", state, 0);

    // Backpressure: pending decision blocks input and stays stable.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 0, 0);
      checkOutput("bp_valid", mon_valid, 1);
      checkOutput("bp_class", mon_class, 0);
      checkOutput("bp_votes", mon_fault_votes, 4);
      checkOutput("bp_count", sample_count, 16);
    end
    applyStimulus(1, 0, 1, 0);
    checkOutput("pass_valid", mon_valid, 1);
    checkOutput("pass_votes", mon_fault_votes, 3);
    checkOutput("pass_count", sample_count, 17);

    // Clear in ALARM with a concurrent valid sample.
    resetDut();
    applyStimulus(0, 0, 1, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 1, 0);
    for (int i = 0; i < 9; i++) applyStimulus(1, 1, 1, 0);
    checkOutput("pre_clear_alarm", alarm, 1);
    applyStimulus(1, 1, 1, 1);
    checkOutput("clear_state", state, 0);
    checkOutput("clear_count", sample_count, 0);
    checkOutput("clear_valid", mon_valid, 0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1, 1, 1, 0);
      checkOutput("clear_refill_valid", mon_valid, 0);
    end
    applyStimulus(1, 1, 1, 0);
    checkOutput("clear_first_valid", mon_valid, 1);
    checkOutput("clear_first_votes", mon_fault_votes, 8);
    checkOutput("clear_first_state", state, 1);

    // Reset mid-window after 5 accepts: asynchronous, window discarded.
    resetDut();
    applyStimulus(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 1, 0);
    rst = 1'b1;
    #1;
    checkResetOutputs("async");
    resetDut();
    applyStimulus(0, 0, 1, 0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1, 0, 1, 0);
      checkOutput("rst_refill_valid", mon_valid, 0);
    end
    applyStimulus(1, 0, 1, 0);
    checkOutput("rst_first_valid", mon_valid, 1);
    checkOutput("rst_first_votes", mon_fault_votes, 0);

    // Randomized traffic with per-block class bias.
    resetDut();
    applyStimulus(0, 0, 1, 0);
    begin
      int p_one = 50;
      for (int n = 0; n < 600; n++) begin
        if (n % 50 == 0) begin
          case ($urandom_range(0, 2))
            0: p_one = 10;
            1: p_one = 50;
            default: p_one = 95;
          endcase
        end
        applyStimulus(($urandom % 100) < 75, (($urandom % 100) < p_one) ? 1 : 0,
                      ($urandom % 100) < 70, ($urandom % 100) < 2);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
